// File: rtl/satagtx_rst_defs.sv
// Shared state encodings and field widths for the SATA GTX reset sequencer.
// Imported by the RTL and by the bench so both agree on the encodings.
package satagtx_rst_defs;

  localparam int STATE_W  = 3;
  localparam int RETRY_W  = 3;
  localparam int WDOG_W   = 16;
  localparam int LOSS_W   = 8;
  localparam int RSTCNT_W = 8;

  localparam logic [2:0] ST_RESET     = 3'd0;
  localparam logic [2:0] ST_WAIT_PLL  = 3'd1;
  localparam logic [2:0] ST_WAIT_DCM  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_READY     = 3'd4;
  localparam logic [2:0] ST_FAIL      = 3'd5;

endpackage

// File: rtl/satagtx_sync2.sv
// Two-flop synchronizer bringing one asynchronous level into the clk domain.
module satagtx_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/satagtx_rst_seq.sv
// GTX tile reset sequencer: pulses gtxreset, waits for PLL/DCM lock and reset done,
// retries on failure. Define SATAGTX_RST_LOSSCNT_EN to build the lock-loss counter.
module satagtx_rst_seq
  import satagtx_rst_defs::*;
#(
  parameter int C_GTXRESET_CYCLES = 8,
  parameter int C_TIMEOUT_CYCLES  = 65535,
  parameter int C_MAX_RETRY       = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tile0_plllkdet,
  input  logic               refclkout_dcm0_locked,
  input  logic               tile0_resetdone0,
  input  logic               soft_reset,
  output logic               tile0_gtxreset,
  output logic               user_rst_n,
  output logic [STATE_W-1:0] seq_state,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               seq_fail,
  output logic [LOSS_W-1:0]  loss_cnt
);

  localparam logic [RSTCNT_W-1:0] RST_LAST    = RSTCNT_W'(C_GTXRESET_CYCLES - 1);
  localparam logic [WDOG_W-1:0]   WDOG_LAST   = WDOG_W'(C_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W:0]    RETRY_LIMIT = (RETRY_W + 1)'(C_MAX_RETRY);

  logic plllkdet_s, dcm_locked_s, resetdone_s;

  satagtx_sync2 u_sync_pll  (.clk(clk), .rst_n(rst_n), .d(tile0_plllkdet),        .q(plllkdet_s));
  satagtx_sync2 u_sync_dcm  (.clk(clk), .rst_n(rst_n), .d(refclkout_dcm0_locked), .q(dcm_locked_s));
  satagtx_sync2 u_sync_done (.clk(clk), .rst_n(rst_n), .d(tile0_resetdone0),      .q(resetdone_s));

  logic [STATE_W-1:0]  state_q, state_d;
  logic [RSTCNT_W-1:0] rst_cnt_q;
  logic [WDOG_W-1:0]   wdog_q;
  logic [RETRY_W-1:0]  retry_q;
  logic                user_rst_n_q, gtxreset_q, seq_fail_q;

  logic in_wait, exit_ok, timeout, pll_lost, attempt_fail, lock_lost, retry_at_limit, state_entry;

  always_comb begin
    in_wait        = (state_q == ST_WAIT_PLL) || (state_q == ST_WAIT_DCM) ||
                     (state_q == ST_WAIT_DONE);
    exit_ok        = 1'b0;
    case (state_q)
      ST_WAIT_PLL:  exit_ok = plllkdet_s;
      ST_WAIT_DCM:  exit_ok = dcm_locked_s;
      ST_WAIT_DONE: exit_ok = resetdone_s;
      default:      exit_ok = 1'b0;
    endcase
    timeout        = in_wait && (wdog_q == WDOG_LAST);
    // Losing the GTX PLL after it was seen locked invalidates the attempt at once.
    pll_lost       = ((state_q == ST_WAIT_DCM) || (state_q == ST_WAIT_DONE)) && !plllkdet_s;
    attempt_fail   = pll_lost || (timeout && !exit_ok);
    lock_lost      = (state_q == ST_READY) && (!plllkdet_s || !dcm_locked_s);
    retry_at_limit = ({1'b0, retry_q} + 1'b1) == RETRY_LIMIT;
  end

  always_comb begin
    state_d = state_q;
    if (soft_reset) begin
      state_d = ST_RESET;
    end else begin
      case (state_q)
        ST_RESET:     if (rst_cnt_q == RST_LAST) state_d = ST_WAIT_PLL;
        ST_WAIT_PLL:  if (attempt_fail) state_d = retry_at_limit ? ST_FAIL : ST_RESET;
                      else if (exit_ok) state_d = ST_WAIT_DCM;
        ST_WAIT_DCM:  if (attempt_fail) state_d = retry_at_limit ? ST_FAIL : ST_RESET;
                      else if (exit_ok) state_d = ST_WAIT_DONE;
        ST_WAIT_DONE: if (attempt_fail) state_d = retry_at_limit ? ST_FAIL : ST_RESET;
                      else if (exit_ok) state_d = ST_READY;
        ST_READY:     if (lock_lost) state_d = ST_RESET;
        ST_FAIL:      state_d = ST_FAIL;
        default:      state_d = ST_RESET;
      endcase
    end
  end

  // A soft reset while already in RESET is still a fresh entry: restart the pulse.
  assign state_entry = (state_d != state_q) || soft_reset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RESET;
      rst_cnt_q    <= '0;
      wdog_q       <= '0;
      retry_q      <= '0;
      user_rst_n_q <= 1'b0;
      gtxreset_q   <= 1'b1;
      seq_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      user_rst_n_q <= (state_d == ST_READY);
      gtxreset_q   <= (state_d == ST_RESET) || (state_d == ST_FAIL);
      seq_fail_q   <= (state_d == ST_FAIL);
      if (state_entry) begin
        rst_cnt_q <= '0;
        wdog_q    <= '0;
      end else begin
        if (state_q == ST_RESET) rst_cnt_q <= rst_cnt_q + 1'b1;
        if (in_wait)             wdog_q    <= wdog_q + 1'b1;
      end
      if (soft_reset || (state_d == ST_READY)) begin
        retry_q <= '0;
      end else if (attempt_fail && !retry_at_limit) begin
        retry_q <= retry_q + 1'b1;
      end
    end
  end

  assign tile0_gtxreset = gtxreset_q;
  assign user_rst_n     = user_rst_n_q;
  assign seq_state      = state_q;
  assign retry_cnt      = retry_q;
  assign seq_fail       = seq_fail_q;

`ifdef SATAGTX_RST_LOSSCNT_EN
  logic [LOSS_W-1:0] loss_q;

  // Only genuine lock loss counts; a soft reset out of READY is not a loss event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else if (lock_lost && !soft_reset && (loss_q != {LOSS_W{1'b1}})) begin
      loss_q <= loss_q + 1'b1;
    end
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_satagtx_rst_seq.sv
// Bench for satagtx_rst_seq: randomized bring-up, lock loss, timeout/FAIL, soft and
// asynchronous reset, checked transition by transition against an expected queue.
module tb_satagtx_rst_seq;
  import satagtx_rst_defs::*;

  localparam int GTX_CYC = 4;
  localparam int TO_CYC  = 100;
  localparam int MAX_RT  = 2;

  logic       clk, rst_n;
  logic       tile0_plllkdet, refclkout_dcm0_locked, tile0_resetdone0, soft_reset;
  logic       tile0_gtxreset, user_rst_n, seq_fail;
  logic [2:0] seq_state, retry_cnt;
  logic [7:0] loss_cnt;

  typedef struct packed {
    logic [2:0] state;
    logic [2:0] retry;
    logic       fail;
    logic       urst;
    logic       gtx;
    logic [7:0] loss;
  } obs_t;

  // len = cycles the state must last before the next change (0: any length)
  typedef struct packed {
    obs_t        o;
    logic        chk_retry;
    logic [15:0] len;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [2:0] m_retry = 3'd0;
  logic [7:0] m_loss  = 8'd0;

  satagtx_rst_seq #(
    .C_GTXRESET_CYCLES(GTX_CYC),
    .C_TIMEOUT_CYCLES (TO_CYC),
    .C_MAX_RETRY      (MAX_RT)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .tile0_plllkdet       (tile0_plllkdet),
    .refclkout_dcm0_locked(refclkout_dcm0_locked),
    .tile0_resetdone0     (tile0_resetdone0),
    .soft_reset           (soft_reset),
    .tile0_gtxreset       (tile0_gtxreset),
    .user_rst_n           (user_rst_n),
    .seq_state            (seq_state),
    .retry_cnt            (retry_cnt),
    .seq_fail             (seq_fail),
    .loss_cnt             (loss_cnt)
  );

  // ---------------- clock / global bound ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "global timeout");
  end

  // ---------------- reference model ----------------
  function automatic obs_t sample();
    obs_t s;
    s.state = seq_state;
    s.retry = retry_cnt;
    s.fail  = seq_fail;
    s.urst  = user_rst_n;
    s.gtx   = tile0_gtxreset;
    s.loss  = loss_cnt;
    return s;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("state=%0d retry=%0d fail=%0d urst_n=%0d gtxrst=%0d loss=%0d",
                     o.state, o.retry, o.fail, o.urst, o.gtx, o.loss);
  endfunction

  task automatic push(input logic [2:0] st, input int len);
    exp_t e;
    e.o.state   = st;
    e.o.retry   = m_retry;
    e.o.fail    = (st == ST_FAIL);
    e.o.urst    = (st == ST_READY);
    e.o.gtx     = (st == ST_RESET) || (st == ST_FAIL);
    e.o.loss    = m_loss;
    e.chk_retry = (st != ST_FAIL);
    e.len       = 16'(len);
    exp_q.push_back(e);
  endtask

  task automatic model_fail_attempt();
    if (int'(m_retry) + 1 == MAX_RT) begin
      push(ST_FAIL, 0);
    end else begin
      m_retry = m_retry + 3'd1;
      push(ST_RESET, GTX_CYC);
    end
  endtask

  task automatic model_lock_loss();
`ifdef SATAGTX_RST_LOSSCNT_EN
    if (m_loss != 8'd255) m_loss = m_loss + 8'd1;
`endif
    push(ST_RESET, GTX_CYC);
  endtask

  task automatic model_bringup(input int pll_len);
    push(ST_WAIT_PLL, pll_len);
    push(ST_WAIT_DCM, 0);
    push(ST_WAIT_DONE, 0);
    m_retry = 3'd0;
    push(ST_READY, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input logic [2:0] rt, input bit use_rt,
                            input int max_cyc, input string name);
    int k;
    k = 0;
    while (!((seq_state == st) && (!use_rt || (retry_cnt == rt))) && (k < max_cyc)) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (k >= max_cyc) begin
      n_fail++;
      $display("FAIL %s: state %0d not reached in %0d cycles (now %0d)", name, st, max_cyc, seq_state);
    end
  endtask

  task automatic raise_locks();
    repeat ($urandom_range(3, 20)) @(negedge clk);
    tile0_plllkdet = 1'b1;
    repeat ($urandom_range(3, 20)) @(negedge clk);
    refclkout_dcm0_locked = 1'b1;
    repeat ($urandom_range(3, 20)) @(negedge clk);
    tile0_resetdone0 = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},  seq_state,      0);
    check({tag, "_gtxrst"}, tile0_gtxreset, 1);
    check({tag, "_urst_n"}, user_rst_n,     0);
    check({tag, "_retry"},  retry_cnt,      0);
    check({tag, "_fail"},   seq_fail,       0);
    check({tag, "_loss"},   loss_cnt,       0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    obs_t        prev, cur, want;
    exp_t        e;
    int          run_len;
    logic [15:0] cur_len;
    @(negedge clk);
    prev    = sample();
    run_len = 0;
    cur_len = 16'(GTX_CYC);
    forever begin
      @(negedge clk);
      cur = sample();
      if (cur != prev) begin
        if (cur_len != 0) check($sformatf("state_len_st%0d", prev.state), run_len, int'(cur_len));
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_change: got %s, expected no change", fmt(cur));
          cur_len = 16'd0;
        end else begin
          e    = exp_q.pop_front();
          want = e.o;
          if (!e.chk_retry) want.retry = cur.retry;
          n_tests++;
          if (cur != want) begin
            n_fail++;
            $display("FAIL transition: got %s expected %s", fmt(cur), fmt(want));
          end
          cur_len = e.len;
        end
        run_len = 1;
        prev    = cur;
      end else begin
        run_len++;
      end
      if (!rst_n) run_len = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int dl, det, nloss;
    bit which;
    tile0_plllkdet        = 1'b0;
    refclkout_dcm0_locked = 1'b0;
    tile0_resetdone0      = 1'b0;
    soft_reset            = 1'b0;
    rst_n                 = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_reset_outputs("por");

    // nominal bring-up
    model_bringup(0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    raise_locks();
    wait_state(ST_READY, 3'd0, 1'b0, 300, "nominal_ready");
    check("nominal_urst_n", user_rst_n, 1);

    // lock loss in READY, random lock and duration
    nloss = $urandom_range(2, 4);
    repeat (nloss) begin
      which = 1'($urandom_range(0, 1));
      dl    = $urandom_range(3, 8);
      det   = 0;
      model_lock_loss();
      model_bringup(0);
      @(negedge clk);
      if (which) tile0_plllkdet = 1'b0;
      else refclkout_dcm0_locked = 1'b0;
      for (int i = 1; i <= 12; i++) begin
        @(negedge clk);
        if ((det == 0) && (user_rst_n == 1'b0)) det = i;
        if (i == dl) begin
          tile0_plllkdet        = 1'b1;
          refclkout_dcm0_locked = 1'b1;
        end
      end
      n_tests++;
      if ((det < 1) || (det > 3)) begin
        n_fail++;
        $display("FAIL loss_latency: got %0d cycles expected 1..3", det);
      end
      wait_state(ST_READY, 3'd0, 1'b0, 300, "loss_ready");
    end

    // all locks gone: two watchdog timeouts end in FAIL
    model_lock_loss();
    push(ST_WAIT_PLL, TO_CYC);
    model_fail_attempt();
    push(ST_WAIT_PLL, TO_CYC);
    model_fail_attempt();
    @(negedge clk);
    tile0_plllkdet        = 1'b0;
    refclkout_dcm0_locked = 1'b0;
    tile0_resetdone0      = 1'b0;
    wait_state(ST_FAIL, 3'd0, 1'b0, 400, "reach_fail");
    check("fail_seq_fail", seq_fail, 1);
    check("fail_gtxrst", tile0_gtxreset, 1);
    check("fail_urst_n", user_rst_n, 0);
    repeat ($urandom_range(5, 20)) @(negedge clk);
    check("fail_terminal", seq_state, 5);

    // soft reset out of FAIL, then soft reset on the very timeout cycle
    m_retry = 3'd0;
    push(ST_RESET, GTX_CYC);
    push(ST_WAIT_PLL, TO_CYC);
    model_fail_attempt();
    push(ST_WAIT_PLL, TO_CYC);
    m_retry = 3'd0;
    push(ST_RESET, GTX_CYC);
    model_bringup(0);
    soft_reset = 1'b1;
    @(negedge clk);
    soft_reset = 1'b0;
    check("soft_fail_state", seq_state, 0);
    check("soft_fail_retry", retry_cnt, 0);
    check("soft_fail_seq_fail", seq_fail, 0);
    wait_state(ST_WAIT_PLL, 3'd1, 1'b1, 400, "second_wait_pll");
    repeat (TO_CYC - 1) @(negedge clk);
    soft_reset = 1'b1;
    @(negedge clk);
    soft_reset = 1'b0;
    check("soft_to_state", seq_state, 0);
    check("soft_to_retry", retry_cnt, 0);
    check("soft_to_seq_fail", seq_fail, 0);
    raise_locks();
    wait_state(ST_READY, 3'd0, 1'b0, 300, "soft_ready");

    // asynchronous rst_n while waiting for reset done
    model_lock_loss();
    push(ST_WAIT_PLL, 0);
    push(ST_WAIT_DCM, 0);
    push(ST_WAIT_DONE, 0);
    @(negedge clk);
    refclkout_dcm0_locked = 1'b0;
    tile0_resetdone0      = 1'b0;
    repeat (4) @(negedge clk);
    refclkout_dcm0_locked = 1'b1;
    wait_state(ST_WAIT_DONE, 3'd0, 1'b0, 100, "reach_wait_done");
    repeat ($urandom_range(1, 5)) @(negedge clk);
    m_retry = 3'd0;
    m_loss  = 8'd0;
    push(ST_RESET, GTX_CYC);
    model_bringup(0);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat ($urandom_range(3, 20)) @(negedge clk);
    tile0_resetdone0 = 1'b1;
    wait_state(ST_READY, 3'd0, 1'b0, 300, "async_ready");

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
